// File: rtl/nv_nvdla_csb_pkg.sv
// Shared CSB constants and helpers used by the csb2cmac arbiter and its ID FIFO.
package nv_nvdla_csb_pkg;

    localparam int CSB_REQ_PD_W        = 63;
    localparam int CSB_RESP_PD_W       = 34;
    localparam int CSB_REQ_WRITE_BIT   = 54;
    localparam int CSB_REQ_NPOSTED_BIT = 55;
    localparam int CSB_RESP_WRACK_BIT  = 33;

    typedef logic csb_port_id_t;

    // Reads and non-posted writes both produce a response on cmac2csb.
    function automatic logic csb_need_resp(input logic [CSB_REQ_PD_W-1:0] pd);
        return ~pd[CSB_REQ_WRITE_BIT] | pd[CSB_REQ_NPOSTED_BIT];
    endfunction

endpackage

// File: rtl/nv_nvdla_csb_id_fifo.sv
// In-order FIFO of requester IDs for responses still owed by the cmac side.
module nv_nvdla_csb_id_fifo
    import nv_nvdla_csb_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  csb_port_id_t     push_data_i,
    input  logic             pop_i,
    output csb_port_id_t     head_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CNT_W-1:0] count_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    csb_port_id_t     mem_q [DEPTH];
    logic             do_push, do_pop;

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];

    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;

    // Depth is a power of two, so pointers wrap by plain overflow.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data_i;
    end

endmodule

// File: rtl/nv_nvdla_csb2cmac_arb.sv
// Two-master round-robin arbiter in front of the csb2cmac retiming stage,
// with in-order steering of cmac2csb responses back to the issuing master.
module nv_nvdla_csb2cmac_arb
    import nv_nvdla_csb_pkg::*;
#(
    parameter int MAX_OUTS = 4,
    parameter int OUTS_W   = 3
) (
    input  logic                     nvdla_core_clk,
    input  logic                     nvdla_core_rst,
    input  logic                     req0_pvld,
    output logic                     req0_prdy,
    input  logic [CSB_REQ_PD_W-1:0]  req0_pd,
    input  logic                     req1_pvld,
    output logic                     req1_prdy,
    input  logic [CSB_REQ_PD_W-1:0]  req1_pd,
    output logic                     dst_req_pvld,
    input  logic                     dst_req_prdy,
    output logic [CSB_REQ_PD_W-1:0]  dst_req_pd,
    input  logic                     dst_resp_valid,
    input  logic [CSB_RESP_PD_W-1:0] dst_resp_pd,
    output logic                     resp0_valid,
    output logic [CSB_RESP_PD_W-1:0] resp0_pd,
    output logic                     resp1_valid,
    output logic [CSB_RESP_PD_W-1:0] resp1_pd,
    output logic [OUTS_W-1:0]        outs_cnt,
    output logic                     err_unexp_resp
);

    logic                     dst_req_pvld_q, dst_req_pvld_d;
    logic [CSB_REQ_PD_W-1:0]  dst_req_pd_q;
    csb_port_id_t             rr_q, rr_d;
    logic                     resp0_valid_q, resp0_valid_d;
    logic                     resp1_valid_q, resp1_valid_d;
    logic [CSB_RESP_PD_W-1:0] resp0_pd_q, resp1_pd_q;
    logic                     err_q, err_d;

    logic                     need0, need1, cand0, cand1, out_free, accept, push, pop;
    csb_port_id_t             grant_id, head_id;
    logic                     fifo_full, fifo_empty;
    logic [CSB_REQ_PD_W-1:0]  grant_pd;

    assign need0 = csb_need_resp(req0_pd);
    assign need1 = csb_need_resp(req1_pd);

    // Full uses the registered count: a same-cycle pop never frees a slot early.
    assign cand0 = req0_pvld & (~need0 | ~fifo_full);
    assign cand1 = req1_pvld & (~need1 | ~fifo_full);

    assign grant_id = (cand0 & cand1) ? rr_q : ~cand0;
    assign out_free = ~dst_req_pvld_q | dst_req_prdy;

    assign req0_prdy = cand0 & (grant_id == 1'b0) & out_free;
    assign req1_prdy = cand1 & (grant_id == 1'b1) & out_free;

    assign accept   = req0_prdy | req1_prdy;
    assign grant_pd = grant_id ? req1_pd : req0_pd;
    assign push     = accept & (grant_id ? need1 : need0);
    assign pop      = dst_resp_valid & ~fifo_empty;

    nv_nvdla_csb_id_fifo #(
        .DEPTH (MAX_OUTS),
        .CNT_W (OUTS_W)
    ) u_id_fifo (
        .clk         (nvdla_core_clk),
        .rst         (nvdla_core_rst),
        .push_i      (push),
        .push_data_i (grant_id),
        .pop_i       (pop),
        .head_o      (head_id),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .count_o     (outs_cnt)
    );

    always_comb begin
        dst_req_pvld_d = dst_req_pvld_q;
        if (accept)
            dst_req_pvld_d = 1'b1;
        else if (dst_req_prdy)
            dst_req_pvld_d = 1'b0;
        rr_d          = accept ? ~grant_id : rr_q;
        resp0_valid_d = pop & (head_id == 1'b0);
        resp1_valid_d = pop & (head_id == 1'b1);
        err_d         = dst_resp_valid & fifo_empty;
    end

    always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
        if (nvdla_core_rst) begin
            dst_req_pvld_q <= 1'b0;
            rr_q           <= 1'b0;
            resp0_valid_q  <= 1'b0;
            resp1_valid_q  <= 1'b0;
            err_q          <= 1'b0;
        end else begin
            dst_req_pvld_q <= dst_req_pvld_d;
            rr_q           <= rr_d;
            resp0_valid_q  <= resp0_valid_d;
            resp1_valid_q  <= resp1_valid_d;
            err_q          <= err_d;
        end
    end

    // Payload registers carry no reset; their valids qualify them.
    always_ff @(posedge nvdla_core_clk) begin
        if (accept)        dst_req_pd_q <= grant_pd;
        if (resp0_valid_d) resp0_pd_q   <= dst_resp_pd;
        if (resp1_valid_d) resp1_pd_q   <= dst_resp_pd;
    end

    assign dst_req_pvld   = dst_req_pvld_q;
    assign dst_req_pd     = dst_req_pd_q;
    assign resp0_valid    = resp0_valid_q;
    assign resp0_pd       = resp0_pd_q;
    assign resp1_valid    = resp1_valid_q;
    assign resp1_pd       = resp1_pd_q;
    assign err_unexp_resp = err_q;

endmodule

// File: tb/tb_nv_nvdla_csb2cmac_arb.sv
// Directed bench for nv_nvdla_csb2cmac_arb with a queue-based reference model checked every cycle.
module tb_nv_nvdla_csb2cmac_arb;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req0_pvld = 1'b0, req1_pvld = 1'b0;
    logic [62:0] req0_pd = '0, req1_pd = '0;
    logic        dst_req_prdy = 1'b1;
    logic        dst_resp_valid = 1'b0;
    logic [33:0] dst_resp_pd = '0;
    logic        req0_prdy, req1_prdy, dst_req_pvld;
    logic [62:0] dst_req_pd;
    logic        resp0_valid, resp1_valid, err_unexp_resp;
    logic [33:0] resp0_pd, resp1_pd;
    logic [2:0]  outs_cnt;

    int errors = 0;
    int checks = 0;

    nv_nvdla_csb2cmac_arb #(.MAX_OUTS(4), .OUTS_W(3)) dut (
        .nvdla_core_clk (clk),
        .nvdla_core_rst (rst),
        .req0_pvld      (req0_pvld),
        .req0_prdy      (req0_prdy),
        .req0_pd        (req0_pd),
        .req1_pvld      (req1_pvld),
        .req1_prdy      (req1_prdy),
        .req1_pd        (req1_pd),
        .dst_req_pvld   (dst_req_pvld),
        .dst_req_prdy   (dst_req_prdy),
        .dst_req_pd     (dst_req_pd),
        .dst_resp_valid (dst_resp_valid),
        .dst_resp_pd    (dst_resp_pd),
        .resp0_valid    (resp0_valid),
        .resp0_pd       (resp0_pd),
        .resp1_valid    (resp1_valid),
        .resp1_pd       (resp1_pd),
        .outs_cnt       (outs_cnt),
        .err_unexp_resp (err_unexp_resp)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [62:0] mk(input bit w, input bit np, input logic [31:0] tag);
        logic [62:0] p;
        p = {31'd0, tag};
        p[54] = w;
        p[55] = np;
        return p;
    endfunction

    function automatic bit need(input logic [62:0] pd);
        return !pd[54] || pd[55];
    endfunction

    // Reference model: outstanding owners as a queue, priority port, output/response registers.
    bit          q[$];
    bit          m_pri = 0;
    bit          m_dst_vld = 0;
    logic [62:0] m_dst_pd = '0;
    bit          m_r0v = 0, m_r1v = 0, m_err = 0;
    logic [33:0] m_r0pd = '0, m_r1pd = '0;
    int          m_g;
    bit          m_id;

    function automatic int model_grant();
        bit full, c0, c1;
        full = (q.size() >= 4);
        c0 = req0_pvld && (!need(req0_pd) || !full);
        c1 = req1_pvld && (!need(req1_pd) || !full);
        if (c0 && c1) return int'(m_pri);
        if (c0) return 0;
        if (c1) return 1;
        return -1;
    endfunction

    initial begin
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                q.delete();
                m_pri = 0; m_dst_vld = 0; m_r0v = 0; m_r1v = 0; m_err = 0;
            end else begin
                m_g = model_grant();
                if (!(m_dst_vld == 0 || dst_req_prdy)) m_g = -1;
                m_r0v = 0; m_r1v = 0; m_err = 0;
                if (dst_resp_valid) begin
                    if (q.size() == 0) m_err = 1;
                    else begin
                        m_id = q.pop_front();
                        if (m_id == 0) begin m_r0v = 1; m_r0pd = dst_resp_pd; end
                        else begin m_r1v = 1; m_r1pd = dst_resp_pd; end
                    end
                end
                if (m_g >= 0) begin
                    m_dst_pd = (m_g == 1) ? req1_pd : req0_pd;
                    if (need(m_dst_pd)) q.push_back(m_g == 1);
                    m_dst_vld = 1;
                    m_pri = (m_g == 0);
                end else if (dst_req_prdy) begin
                    m_dst_vld = 0;
                end
            end
        end
    end

    initial begin
        int  g;
        bit  free;
        forever begin
            @(negedge clk);
            if (!rst) begin
                g = model_grant();
                free = !m_dst_vld || dst_req_prdy;
                chk("m_req0_prdy", req0_prdy, (g == 0) && free);
                chk("m_req1_prdy", req1_prdy, (g == 1) && free);
                chk("m_dst_pvld", dst_req_pvld, m_dst_vld);
                if (m_dst_vld) chk("m_dst_pd", dst_req_pd, m_dst_pd);
                chk("m_resp0_valid", resp0_valid, m_r0v);
                chk("m_resp1_valid", resp1_valid, m_r1v);
                if (m_r0v) chk("m_resp0_pd", resp0_pd, m_r0pd);
                if (m_r1v) chk("m_resp1_pd", resp1_pd, m_r1pd);
                chk("m_outs_cnt", outs_cnt, q.size());
                chk("m_err", err_unexp_resp, m_err);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        repeat (2) tick();
        rst = 1'b0;
        @(negedge clk);
        chk("rst_dst_pvld", dst_req_pvld, 0);
        chk("rst_outs", outs_cnt, 0);
        chk("rst_resp_valids", {resp0_valid, resp1_valid, err_unexp_resp}, 0);
        tick();

        // Single read from port 0 and its response
        req0_pd = mk(0, 0, 32'h111); req0_pvld = 1;
        @(negedge clk); chk("t1_req0_prdy", req0_prdy, 1);
        tick(); req0_pvld = 0;
        @(negedge clk);
        chk("t1_dst_pvld", dst_req_pvld, 1);
        chk("t1_dst_pd", dst_req_pd, mk(0, 0, 32'h111));
        chk("t1_outs", outs_cnt, 1);
        repeat (2) tick();
        dst_resp_valid = 1; dst_resp_pd = 34'h0_DEADBEEF;
        tick(); dst_resp_valid = 0;
        @(negedge clk);
        chk("t1_resp0_valid", resp0_valid, 1);
        chk("t1_resp0_pd", resp0_pd, 34'h0_DEADBEEF);
        chk("t1_resp1_valid", resp1_valid, 0);
        chk("t1_outs0", outs_cnt, 0);
        tick();

        // Posted writes on both ports alternate; port 1 has priority after port 0 won last
        req0_pd = mk(1, 0, 32'h200); req1_pd = mk(1, 0, 32'h201);
        req0_pvld = 1; req1_pvld = 1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("t2_req1_prdy", req1_prdy, (i % 2) == 0);
            chk("t2_req0_prdy", req0_prdy, (i % 2) == 1);
            if (i > 0) begin
                chk("t2_dst_pvld", dst_req_pvld, 1);
                chk("t2_dst_pd", dst_req_pd, (i % 2) == 1 ? mk(1, 0, 32'h201) : mk(1, 0, 32'h200));
                chk("t2_outs", outs_cnt, 0);
            end
            tick();
        end
        req0_pvld = 0; req1_pvld = 0;
        tick();

        // Fill outstanding FIFO from port 1; posted write on port 0 still passes
        req1_pd = mk(0, 0, 32'h300); req1_pvld = 1;
        repeat (4) tick();
        req0_pd = mk(1, 0, 32'h301); req0_pvld = 1;
        @(negedge clk);
        chk("t3_outs_full", outs_cnt, 4);
        chk("t3_req1_blocked", req1_prdy, 0);
        chk("t3_req0_posted", req0_prdy, 1);
        tick(); req0_pvld = 0;
        dst_resp_valid = 1; dst_resp_pd = 34'h2_00000001;
        @(negedge clk); chk("t3_req1_pop_cycle", req1_prdy, 0);
        tick(); dst_resp_valid = 0;
        @(negedge clk);
        chk("t3_resp1_valid", resp1_valid, 1);
        chk("t3_resp1_pd", resp1_pd, 34'h2_00000001);
        chk("t3_outs3", outs_cnt, 3);
        chk("t3_req1_prdy", req1_prdy, 1);
        tick(); req1_pvld = 0;
        @(negedge clk); chk("t3_outs4", outs_cnt, 4);
        dst_resp_valid = 1;
        for (int i = 0; i < 4; i++) begin
            dst_resp_pd = 34'(32'h310 + i);
            tick();
        end
        dst_resp_valid = 0;
        @(negedge clk);
        chk("t3_drain_resp1", resp1_valid, 1);
        chk("t3_drain_outs", outs_cnt, 0);
        repeat (2) tick();

        // Back-pressure from the retiming stage holds the output register
        dst_req_prdy = 0;
        req0_pd = mk(1, 0, 32'h400); req0_pvld = 1;
        @(negedge clk); chk("t4_first_prdy", req0_prdy, 1);
        tick(); req0_pd = mk(1, 0, 32'h401);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t4_stall_prdy", req0_prdy, 0);
            chk("t4_hold_pd", dst_req_pd, mk(1, 0, 32'h400));
            tick();
        end
        dst_req_prdy = 1;
        @(negedge clk); chk("t4_recover_prdy", req0_prdy, 1);
        tick(); req0_pvld = 0;
        @(negedge clk); chk("t4_new_pd", dst_req_pd, mk(1, 0, 32'h401));
        tick();

        // Interleaved reads route responses in order; extra response is unexpected
        req0_pd = mk(0, 0, 32'h500); req0_pvld = 1; tick(); req0_pvld = 0;
        req1_pd = mk(0, 0, 32'h501); req1_pvld = 1; tick(); req1_pvld = 0;
        req0_pd = mk(0, 1, 32'h502); req0_pvld = 1; tick(); req0_pvld = 0;
        @(negedge clk); chk("t5_outs3", outs_cnt, 3);
        dst_resp_valid = 1; dst_resp_pd = 34'h11;
        tick(); dst_resp_pd = 34'h22;
        @(negedge clk);
        chk("t5_r0_valid", resp0_valid, 1); chk("t5_r0_pd", resp0_pd, 34'h11);
        chk("t5_r0_other", resp1_valid, 0);
        tick(); dst_resp_pd = 34'h2_00000033;
        @(negedge clk);
        chk("t5_r1_valid", resp1_valid, 1); chk("t5_r1_pd", resp1_pd, 34'h22);
        chk("t5_r1_other", resp0_valid, 0);
        tick(); dst_resp_pd = 34'h44;
        @(negedge clk);
        chk("t5_r2_valid", resp0_valid, 1); chk("t5_r2_pd", resp0_pd, 34'h2_00000033);
        tick(); dst_resp_valid = 0;
        @(negedge clk);
        chk("t5_err", err_unexp_resp, 1);
        chk("t5_err_no_valid", {resp0_valid, resp1_valid}, 0);
        tick();
        @(negedge clk); chk("t5_err_one_cycle", err_unexp_resp, 0);
        tick();

        // Asynchronous reset with requests outstanding
        req0_pd = mk(0, 0, 32'h600); req0_pvld = 1;
        repeat (2) tick();
        req0_pvld = 0;
        chk("t6_outs_pre", outs_cnt, 2);
        chk("t6_pvld_pre", dst_req_pvld, 1);
        rst = 1;
        #1;
        chk("t6_outs_rst", outs_cnt, 0);
        chk("t6_pvld_rst", dst_req_pvld, 0);
        chk("t6_valids_rst", {resp0_valid, resp1_valid, err_unexp_resp}, 0);
        repeat (2) tick();
        rst = 0;
        dst_resp_valid = 1; dst_resp_pd = 34'h77;
        tick(); dst_resp_valid = 0;
        @(negedge clk);
        chk("t6_err_after_rst", err_unexp_resp, 1);
        chk("t6_no_valid", {resp0_valid, resp1_valid}, 0);
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
